uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Serialising UART transmitter, the transmit-side counterpart of the team's UART receiver. Pops one WIDTH-bit word from the transmit FIFO and sends it on a single line as start bit, data LSB-first, parity bit and stop bit. Holds the line high when idle, and sends frames back-to-back while the FIFO has data. Sits between the TX FIFO read port and the serial pin.

## Interface
- WIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 1, clk cycles per serial bit, ≥1. The default of 1 gives one bit per clock, matching the receiver.
- PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data), 1 = odd parity (inverted XOR).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  TX FIFO empty flag.
- fifo_rd_en  output  1  one-cycle FIFO pop strobe.
- fifo_data  input  WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- tx_data  output  1  serial line, registered.
- busy  output  1  high from the LOAD state through the end of STOP.
- tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- States:
  - IDLE: tx_data=1. fifo_rd_en = !fifo_empty (combinational). If asserted, go to LOAD.
  - LOAD: capture fifo_data into the shift register, compute the parity bit, then go to START. tx_data stays 1 for this cycle.
  - START: tx_data=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_data = shift_reg[0]; shift right each bit period. WIDTH bits are sent, counted by a $clog2(WIDTH)+1-bit bit counter. Then go to PARITY.
  - PARITY: tx_data = parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_data=1 for CLKS_PER_BIT cycles. On the last cycle:
    - tx_done=1.
    - If !fifo_empty, fifo_rd_en=1 and go to LOAD; otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every state change.
  - Width is $clog2(CLKS_PER_BIT)+1.
  - When CLKS_PER_BIT=1, every bit state lasts exactly one cycle.
- Pop rule: fifo_rd_en is never asserted when fifo_empty=1. At most one pop per frame.
- Data register: the captured word is held for the whole frame. Changes on fifo_data after LOAD have no effect.
- Reset value of every output:
  - tx_data = 1
  - fifo_rd_en = 0
  - busy = 0
  - tx_done = 0
- Reset state: IDLE, with all counters and the shift register at 0.
- Reset mid-frame: the frame is aborted and tx_data is 1 on the cycle after rst is sampled. The aborted word is lost and is not re-popped.
- While rst=1, fifo_rd_en=0 regardless of fifo_empty.

## Timing
- Pop at cycle T (IDLE, fifo_empty=0): fifo_rd_en=1 at T, LOAD at T+1.
- The start bit is driven on tx_data from cycle T+2.
- Frame length is (WIDTH+3)×CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Data bit i occupies cycles T+2+(1+i)×CLKS_PER_BIT … +CLKS_PER_BIT−1.
- Back-to-back frames: exactly one idle-high cycle (LOAD) between the end of a stop bit and the next start bit.
- tx_done and a chained fifo_rd_en can be asserted in the same cycle.
- busy rises in LOAD (T+1) and falls the cycle after the last stop-bit cycle if the FIFO is empty; otherwise it stays high.
- fifo_empty going low during a frame is only sampled in IDLE or on the last STOP cycle.

## Test plan
- Reset, then fifo_empty=1 held for 50 cycles -> tx_data=1, fifo_rd_en=0, busy=0, tx_done=0 throughout.
- CLKS_PER_BIT=1, word 0xA5 -> tx_data from T+2 is 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, even parity 0, stop). tx_done pulses on the stop cycle.
- Word 0x07 with PARITY_ODD=0 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Data bits 1,1,1,0,0,0,0,0.
- CLKS_PER_BIT=4, word 0x3C -> each bit held exactly 4 cycles, frame 44 cycles, busy high for 45 cycles, exactly one fifo_rd_en pulse.
- FIFO holding 0x11, 0x22, 0x33 with CLKS_PER_BIT=1 -> three frames separated by exactly one high cycle, three rd_en pulses (two coinciding with tx_done), then IDLE.
- rst asserted in the 5th data bit of 0xFF -> tx_data=1 and busy=0 the next cycle. After release with fifo_empty=0, the next word is popped and sent as a full frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Purpose: serialising UART transmitter that pops words from a TX FIFO and sends
//          start, WIDTH data bits LSB-first, parity and stop on one serial line.
// Latency/backpressure: start bit appears two cycles after the pop strobe; pops
//          only when the FIFO is non-empty and the line is idle or finishing a stop bit.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   fifo_empty  TX FIFO empty flag
//   fifo_rd_en  one-cycle FIFO pop strobe (combinational)
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   tx_data     registered serial line, idles high
//   busy        high from LOAD through the last stop-bit cycle
//   tx_done     one-cycle pulse on the last stop-bit cycle
module uart_tx_frame #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             tx_data,
  output logic             busy,
  output logic             tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W  = $clog2(WIDTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [WIDTH-1:0]  shift_reg, shift_nxt;
  logic              parity_bit, parity_nxt;
  logic              tx_nxt;
  logic              bit_end;

  // Last clock of the current bit period.
  assign bit_end = (baud_cnt == BAUD_LAST);

  assign busy = (state != S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx_data    <= 1'b1;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_reg  <= shift_nxt;
      parity_bit <= parity_nxt;
      tx_data    <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_reg;
    parity_nxt   = parity_bit;
    fifo_rd_en   = 1'b0;
    tx_done      = 1'b0;
    baud_cnt_nxt = baud_cnt;
    tx_nxt       = 1'b1;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        // FIFO read data is valid now, one cycle after the pop.
        shift_nxt   = fifo_data;
        parity_nxt  = (^fifo_data) ^ PARITY_ODD;
        bit_cnt_nxt = '0;
        state_nxt   = S_START;
      end
      S_START: begin
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_nxt = S_PARITY;
          end else begin
            shift_nxt   = shift_reg >> 1;
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          tx_done = 1'b1;
          // Chain straight into the next frame so only LOAD separates them.
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            state_nxt  = S_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Strobes stay quiet while reset is held, even mid-frame.
    if (rst) begin
      fifo_rd_en = 1'b0;
      tx_done    = 1'b0;
    end

    // Baud counter restarts on every state change and at each bit boundary.
    if ((state_nxt != state) || bit_end || (state == S_IDLE)) begin
      baud_cnt_nxt = '0;
    end else begin
      baud_cnt_nxt = baud_cnt + 1'b1;
    end

    // tx_data is registered, so it is computed from the state being entered.
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shift_nxt[0];
      S_PARITY: tx_nxt = parity_nxt;
      default:  tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       fe  [2];
  logic [7:0] fd  [2];
  logic       rd  [2];
  logic       txd [2];
  logic       bsy [2];
  logic       dn  [2];

  // Instance 0: one clock per bit, even parity. Instance 1: four clocks per bit, odd parity.
  uart_tx_frame #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) u_fast (
    .clk(clk), .rst(rst), .fifo_empty(fe[0]), .fifo_rd_en(rd[0]),
    .fifo_data(fd[0]), .tx_data(txd[0]), .busy(bsy[0]), .tx_done(dn[0])
  );

  uart_tx_frame #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) u_slow (
    .clk(clk), .rst(rst), .fifo_empty(fe[1]), .fifo_rd_en(rd[1]),
    .fifo_data(fd[1]), .tx_data(txd[1]), .busy(bsy[1]), .tx_done(dn[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int busy_until [2];
  int last_pop   [2];
  int model_pops [2];
  int pops_seen  [2];
  int rst_cycle  = -1;
  logic force_rst = 1'b1;
  logic rand_rst  = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       pend   [2];
  logic [7:0] pend_w [2];

  logic exp_tx   [2][MAXC];
  logic exp_busy [2][MAXC];
  logic exp_done [2][MAXC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int cpb_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic pushw(input int k, input logic [7:0] w);
    if (k == 0) q0.push_back(w);
    else        q1.push_back(w);
  endtask

  task automatic popw(input int k, output logic [7:0] w);
    if (k == 0) w = q0.pop_front();
    else        w = q1.pop_front();
  endtask

  // Lay out the expected line waveform of one frame popped at cycle t.
  task automatic sched(input int k, input int t, input logic [7:0] w);
    int         cpb;
    int         last;
    logic [10:0] bits;
    cpb  = cpb_of(k);
    bits = {1'b1, (^w) ^ (k == 1), w, 1'b0};
    last = t + 1 + 11 * cpb;
    for (int j = 0; j < 11; j++)
      for (int m = 0; m < cpb; m++)
        exp_tx[k][t + 2 + j * cpb + m] = bits[j];
    for (int i = t + 1; i <= last; i++) exp_busy[k][i] = 1'b1;
    exp_done[k][last] = 1'b1;
    busy_until[k]     = last;
  endtask

  task automatic evaluate();
    logic       exp_rd;
    logic [7:0] w;
    for (int k = 0; k < 2; k++) begin
      exp_rd = !rst && (qsize(k) != 0) && (busy_until[k] <= cyc);
      chk($sformatf("tx%0d", k),   32'(txd[k]), 32'(exp_tx[k][cyc]));
      chk($sformatf("busy%0d", k), 32'(bsy[k]), 32'(exp_busy[k][cyc] && !rst));
      chk($sformatf("done%0d", k), 32'(dn[k]),  32'(exp_done[k][cyc] && !rst));
      chk($sformatf("rd%0d", k),   32'(rd[k]),  32'(exp_rd));
      if (rd[k] === 1'b1) pops_seen[k]++;
      if (exp_rd) begin
        popw(k, w);
        pend[k]   = 1'b1;
        pend_w[k] = w;
        last_pop[k] = cyc;
        model_pops[k]++;
        sched(k, cyc, w);
      end
      if (rst) begin
        busy_until[k] = -1;
        for (int i = cyc + 1; i < cyc + 100 && i < MAXC; i++) begin
          exp_tx[k][i]   = 1'b1;
          exp_busy[k][i] = 1'b0;
          exp_done[k][i] = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive inputs just after the edge, sample and check at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      // Read data is only valid after a pop; otherwise it is scrambled.
      fd[k]   = pend[k] ? pend_w[k] : 8'($urandom);
      pend[k] = 1'b0;
      fe[k]   = (qsize(k) == 0);
    end
    rst = force_rst || rand_rst || ((cyc + 1) == rst_cycle);
    @(negedge clk);
    cyc++;
    evaluate();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && (qsize(0) != 0 || qsize(1) != 0 ||
                          busy_until[0] >= cyc || busy_until[1] >= cyc)) begin
      tick();
      n++;
    end
    if (n >= budget) chk("idle_timeout", 32'd1, 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      fe[k] = 1'b1;
      fd[k] = '0;
      pend[k] = 1'b0;
      pend_w[k] = '0;
      busy_until[k] = -1;
      last_pop[k] = -1;
      model_pops[k] = 0;
      pops_seen[k] = 0;
      for (int i = 0; i < MAXC; i++) begin
        exp_tx[k][i]   = 1'b1;
        exp_busy[k][i] = 1'b0;
        exp_done[k][i] = 1'b0;
      end
    end
    rst = 1'b1;
    @(posedge clk);
    repeat (3) tick();
    force_rst = 1'b0;

    // Idle line with an empty FIFO.
    repeat (50) tick();

    // Directed words.
    pushw(0, 8'hA5);
    wait_idle(200);
    pushw(0, 8'h07);
    pushw(1, 8'h07);
    wait_idle(200);
    pushw(1, 8'h3C);
    wait_idle(200);
    pushw(0, 8'h11);
    pushw(0, 8'h22);
    pushw(0, 8'h33);
    wait_idle(200);
    chk("pops_fast_directed", 32'(pops_seen[0]), 32'd5);
    chk("pops_slow_directed", 32'(pops_seen[1]), 32'd2);

    // Reset during the fifth data bit of 0xFF; the following word must still go out.
    last_pop[0] = -1;
    pushw(0, 8'hFF);
    pushw(0, 8'h5A);
    for (int n = 0; n < 20 && last_pop[0] < 0; n++) tick();
    if (last_pop[0] < 0) chk("pop_timeout", 32'd1, 32'd0);
    rst_cycle = last_pop[0] + 7;
    wait_idle(300);
    rst_cycle = -1;

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      int k;
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0 && qsize(k) < 4) pushw(k, 8'($urandom));
      rand_rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rand_rst = 1'b0;
    wait_idle(3000);

    chk("pops_fast_total", 32'(pops_seen[0]), 32'(model_pops[0]));
    chk("pops_slow_total", 32'(pops_seen[1]), 32'(model_pops[1]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
